// File: rtl/wb_pipe_master.sv
// Pipelined Wishbone B4 burst master: each command becomes up to MAX_BURST beats, at most MAX_OUT in flight.
// Define WB_PIPE_TIMEOUT_EN to abort a burst whose acks stop arriving for TIMEOUT_CYCLES cycles.
module wb_pipe_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int MAX_BURST      = 16,
  parameter int MAX_OUT        = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int BYTE_WIDTH    = DATA_WIDTH / 8,
  localparam int LSB           = $clog2(BYTE_WIDTH),
  localparam int WA_W          = ADDR_WIDTH - LSB,
  localparam int LEN_W         = $clog2(MAX_BURST) + 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [WA_W-1:0]       cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  cmd_we,
  input  logic [BYTE_WIDTH-1:0] cmd_sel,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic                  err,
  output logic                  m_wb_cyc,
  output logic                  m_wb_stb,
  output logic                  m_wb_we,
  output logic [WA_W-1:0]       m_wb_adr,
  output logic [DATA_WIDTH-1:0] m_wb_dat_o,
  output logic [BYTE_WIDTH-1:0] m_wb_sel,
  input  logic [DATA_WIDTH-1:0] m_wb_dat_i,
  input  logic                  m_wb_ack,
  input  logic                  m_wb_err,
  input  logic                  m_wb_stall
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state_q;
  logic [WA_W-1:0]  addr_q;
  logic [LEN_W-1:0] len_q, issued_q, acked_q;
  logic [LEN_W-1:0] outstanding, issued_nxt, acked_nxt, out_nxt;
  logic             accept, ack_ok, timeout, err_hit;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0) return LEN_W'(1);
    if (l > LEN_W'(MAX_BURST)) return LEN_W'(MAX_BURST);
    return l;
  endfunction

  // Counters advance for this cycle's accept and ack together; an ack with nothing in flight is dropped.
  assign outstanding = issued_q - acked_q;
  assign accept      = m_wb_stb && !m_wb_stall;
  assign ack_ok      = m_wb_cyc && m_wb_ack && (outstanding != '0);
  assign err_hit     = m_wb_cyc && (m_wb_err || timeout);
  assign issued_nxt  = issued_q + LEN_W'(accept);
  assign acked_nxt   = acked_q + LEN_W'(ack_ok);
  assign out_nxt     = issued_nxt - acked_nxt;

  assign cmd_ready   = (state_q == IDLE);
  assign wr_ready    = accept && m_wb_we;
  assign m_wb_dat_o  = (m_wb_cyc && m_wb_we) ? wr_data : '0;

`ifdef WB_PIPE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  assign timeout = (to_cnt_q >= TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge aclk) begin
    if (!aresetn || state_q == IDLE || ack_ok) to_cnt_q <= '0;
    else if (outstanding != '0 && !timeout)    to_cnt_q <= to_cnt_q + TO_W'(1);
  end
`else
  // Without the timeout option the master waits for acks indefinitely.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // NOTE: the reset is synchronous, so it sits inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      acked_q  <= '0;
      m_wb_cyc <= 1'b0;
      m_wb_stb <= 1'b0;
      m_wb_we  <= 1'b0;
      m_wb_adr <= '0;
      m_wb_sel <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q  <= ISSUE;
            addr_q   <= cmd_addr;
            len_q    <= clamp_len(cmd_len);
            issued_q <= '0;
            acked_q  <= '0;
            m_wb_cyc <= 1'b1;
            m_wb_stb <= 1'b1;
            m_wb_we  <= cmd_we;
            m_wb_adr <= cmd_addr;
            m_wb_sel <= cmd_sel;
          end
        end
        ISSUE, DRAIN: begin
          issued_q <= issued_nxt;
          acked_q  <= acked_nxt;
          m_wb_adr <= addr_q + WA_W'(issued_nxt);
          if (ack_ok && !m_wb_we) begin
            rd_valid <= 1'b1;
            rd_data  <= m_wb_dat_i;
            rd_last  <= (acked_nxt == len_q);
          end
          if (err_hit || acked_nxt == len_q) begin
            state_q  <= DONE;
            done     <= 1'b1;
            err      <= err_hit;
            m_wb_cyc <= 1'b0;
            m_wb_stb <= 1'b0;
            m_wb_we  <= 1'b0;
            m_wb_adr <= '0;
            m_wb_sel <= '0;
          end else if (issued_nxt == len_q) begin
            state_q  <= DRAIN;
            m_wb_stb <= 1'b0;
          end else begin
            m_wb_stb <= (out_nxt < LEN_W'(MAX_OUT));
          end
        end
        DONE: begin
          state_q <= IDLE;
          err     <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          m_wb_cyc <= 1'b0;
          m_wb_stb <= 1'b0;
          m_wb_we  <= 1'b0;
          m_wb_adr <= '0;
          m_wb_sel <= '0;
          err      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_pipe_master.sv
// Self-checking bench for wb_pipe_master: a behavioural pipelined slave with configurable latency,
// stall and error injection, plus a read-data scoreboard filled as the slave acks.
module tb_wb_pipe_master;

  localparam int AW = 32, DW = 64, MB = 16, MO = 4, TO = 16;
  localparam int WA_W = 29, LEN_W = 5, BW = 8;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [WA_W-1:0]  cmd_addr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_we = 1'b0;
  logic [BW-1:0]    cmd_sel = '0;
  logic [DW-1:0]    wr_data = '0;
  logic             wr_ready, rd_valid, rd_last, done, err;
  logic [DW-1:0]    rd_data;
  logic             m_wb_cyc, m_wb_stb, m_wb_we;
  logic [WA_W-1:0]  m_wb_adr;
  logic [DW-1:0]    m_wb_dat_o;
  logic [BW-1:0]    m_wb_sel;
  logic [DW-1:0]    m_wb_dat_i = '0;
  logic             m_wb_ack = 1'b0, m_wb_err = 1'b0, m_wb_stall = 1'b0;

  wb_pipe_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .MAX_OUT(MO),
                   .TIMEOUT_CYCLES(TO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_we(cmd_we), .cmd_sel(cmd_sel), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .done(done), .err(err),
    .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb), .m_wb_we(m_wb_we), .m_wb_adr(m_wb_adr),
    .m_wb_dat_o(m_wb_dat_o), .m_wb_sel(m_wb_sel), .m_wb_dat_i(m_wb_dat_i),
    .m_wb_ack(m_wb_ack), .m_wb_err(m_wb_err), .m_wb_stall(m_wb_stall)
  );

  always #5 aclk = ~aclk;

  int n_pass = 0, n_total = 0;

  // Slave configuration, set by the tests.
  int ack_lat = 1, stall_left = 0, err_on_ack = 0, exp_len = 1;
  bit never_ack = 1'b0, stray_ack = 1'b0;
  logic [WA_W-1:0] stall_adr = '0;
  logic            exp_we = 1'b0;
  logic [BW-1:0]   exp_sel = '0;

  // Slave state and observed statistics.
  int cyc_n = 0, outst = 0, acks_sent = 0;
  int pend_due[$];
  logic [DW-1:0] pend_dat[$];
  logic [DW-1:0] exp_rd[$];
  logic          exp_last[$];
  logic [WA_W-1:0] acc_adr[$];
  int acc_cyc[$];
  int n_acc, n_wr_ready, n_rd, n_done, max_out, n_gap, wr_bad, attr_bad, stall_bad;
  int last_ack_cyc, done_cyc, err_cyc;
  logic done_err, cyc_after_err;

  function automatic logic [DW-1:0] slave_data(input logic [WA_W-1:0] a);
    return 64'hC0DE_0000_0000_0000 | 64'(a);
  endfunction

  // Slave drives on the falling edge, then samples DUT outputs 1 time unit later.
  always begin
    logic [DW-1:0] d;
    logic [DW-1:0] ed;
    logic          el;
    @(negedge aclk);
    cyc_n++;
    m_wb_ack = 1'b0;
    m_wb_err = 1'b0;
    m_wb_dat_i = '0;
    if (!m_wb_cyc) begin
      pend_due.delete();
      pend_dat.delete();
      outst = 0;
    end
    if (m_wb_cyc && !m_wb_stb && outst == MO) n_gap++;
    m_wb_stall = m_wb_stb && (stall_left > 0);
    if (m_wb_stall) stall_left--;
    if (stray_ack && m_wb_cyc && outst == 0) begin
      m_wb_ack = 1'b1;
      m_wb_dat_i = 64'hDEAD_BEEF;
      stray_ack = 1'b0;
    end else if (pend_due.size() > 0 && pend_due[0] <= cyc_n) begin
      void'(pend_due.pop_front());
      d = pend_dat.pop_front();
      acks_sent++;
      if (acks_sent == err_on_ack) begin
        m_wb_err = 1'b1;
        err_cyc = cyc_n;
        pend_due.delete();
        pend_dat.delete();
      end else begin
        m_wb_ack = 1'b1;
        m_wb_dat_i = d;
        outst--;
        last_ack_cyc = cyc_n;
        if (!m_wb_we) begin
          exp_rd.push_back(d);
          exp_last.push_back(acks_sent == exp_len);
        end
      end
    end
    wr_data = 64'h5A00_0000_0000_0000 + 64'(n_acc);
    #1;
    if (m_wb_stb && !m_wb_stall) begin
      n_acc++;
      outst++;
      if (outst > max_out) max_out = outst;
      acc_adr.push_back(m_wb_adr);
      acc_cyc.push_back(cyc_n);
      if (m_wb_sel !== exp_sel || m_wb_we !== exp_we) attr_bad++;
      if (!never_ack) begin
        pend_due.push_back(cyc_n + ack_lat);
        pend_dat.push_back(slave_data(m_wb_adr));
      end
      if (m_wb_we) begin
        n_total++;
        if (m_wb_dat_o !== wr_data)
          $display("FAIL wr_dat_o: got %h want %h", m_wb_dat_o, wr_data);
        else n_pass++;
      end
    end
    if (wr_ready !== (m_wb_stb && !m_wb_stall && m_wb_we)) wr_bad++;
    if (wr_ready) n_wr_ready++;
    if (m_wb_stall && m_wb_adr !== stall_adr) stall_bad++;
    if (cyc_n == err_cyc + 1) cyc_after_err = m_wb_cyc;
    if (rd_valid) begin
      n_rd++;
      n_total++;
      if (exp_rd.size() == 0) begin
        $display("FAIL rd_unexpected: got data %h, want no read beat", rd_data);
      end else begin
        ed = exp_rd.pop_front();
        el = exp_last.pop_front();
        if (rd_data !== ed || rd_last !== el)
          $display("FAIL rd_beat: got %h last %b want %h last %b", rd_data, rd_last, ed, el);
        else n_pass++;
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc_n;
      done_err = err;
    end
  end

  task automatic clear_stats();
    n_acc = 0; n_wr_ready = 0; n_rd = 0; n_done = 0; max_out = 0; n_gap = 0;
    wr_bad = 0; attr_bad = 0; stall_bad = 0; acks_sent = 0;
    last_ack_cyc = -1; done_cyc = -1; err_cyc = -100; done_err = 1'bx; cyc_after_err = 1'bx;
    acc_adr.delete(); acc_cyc.delete();
  endtask

  task automatic send_cmd(input logic [WA_W-1:0] a, input logic [LEN_W-1:0] l,
                          input logic w, input logic [BW-1:0] s);
    int k;
    exp_we = w;
    exp_sel = s;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_we = w; cmd_sel = s;
    #1;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge aclk);
      #1;
      k++;
    end
    n_total++;
    if (!cmd_ready) $display("FAIL cmd_handshake: cmd_ready stuck at %b, want 1", cmd_ready);
    else n_pass++;
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (n_done == 0 && k < bound) begin
      @(negedge aclk);
      #2;
      k++;
    end
    n_total++;
    if (n_done == 0) $display("FAIL done_timeout: no done within %0d cycles", bound);
    else n_pass++;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    #2;
    n_total++;
    if ({cmd_ready, m_wb_cyc, m_wb_stb, m_wb_we, done, err, rd_valid, rd_last} !== 8'b1000_0000)
      $display("FAIL reset_ctrl: got %b want 10000000",
               {cmd_ready, m_wb_cyc, m_wb_stb, m_wb_we, done, err, rd_valid, rd_last});
    else n_pass++;
    n_total++;
    if (m_wb_adr !== '0 || m_wb_sel !== '0 || m_wb_dat_o !== '0 || rd_data !== '0)
      $display("FAIL reset_data: adr %h sel %h dat_o %h rd_data %h, want all 0",
               m_wb_adr, m_wb_sel, m_wb_dat_o, rd_data);
    else n_pass++;
  endtask

  task automatic test_read4();
    clear_stats();
    ack_lat = 1; exp_len = 4;
    send_cmd(29'h100, 5'd4, 1'b0, 8'hFF);
    wait_done(50);
    n_total++;
    if (n_acc !== 4) $display("FAIL read4_accepts: got %0d want 4", n_acc);
    else n_pass++;
    for (int i = 0; i < 4 && i < acc_adr.size(); i++) begin
      n_total++;
      if (acc_adr[i] !== 29'(32'h100 + i) || acc_cyc[i] !== acc_cyc[0] + i)
        $display("FAIL read4_adr%0d: got %h at cycle %0d want %h at cycle %0d",
                 i, acc_adr[i], acc_cyc[i], 32'h100 + i, acc_cyc[0] + i);
      else n_pass++;
    end
    n_total++;
    if (n_rd !== 4 || done_err !== 1'b0 || done_cyc !== last_ack_cyc + 1)
      $display("FAIL read4_done: rd %0d err %b done_cyc %0d want rd 4 err 0 done_cyc %0d",
               n_rd, done_err, done_cyc, last_ack_cyc + 1);
    else n_pass++;
  endtask

  task automatic test_write8();
    clear_stats();
    ack_lat = 4; exp_len = 8;
    send_cmd(29'h40, 5'd8, 1'b1, 8'hF0);
    wait_done(100);
    n_total++;
    if (n_acc !== 8 || n_wr_ready !== 8 || wr_bad !== 0 || attr_bad !== 0)
      $display("FAIL write8_beats: acc %0d wr_ready %0d wr_bad %0d attr_bad %0d want 8 8 0 0",
               n_acc, n_wr_ready, wr_bad, attr_bad);
    else n_pass++;
    n_total++;
    if (max_out !== MO || n_gap == 0)
      $display("FAIL write8_outstanding: max %0d gaps %0d want max %0d gaps >0", max_out, n_gap, MO);
    else n_pass++;
    n_total++;
    if (done_err !== 1'b0 || n_rd !== 0)
      $display("FAIL write8_done: err %b rd %0d want err 0 rd 0", done_err, n_rd);
    else n_pass++;
  endtask

  task automatic test_stall();
    clear_stats();
    ack_lat = 1; exp_len = 2; stall_left = 5; stray_ack = 1'b1; stall_adr = 29'h200;
    send_cmd(29'h200, 5'd2, 1'b0, 8'h0F);
    wait_done(50);
    n_total++;
    if (n_acc !== 2 || n_rd !== 2 || stall_bad !== 0 || done_err !== 1'b0)
      $display("FAIL stall_read: acc %0d rd %0d stall_bad %0d err %b want 2 2 0 0",
               n_acc, n_rd, stall_bad, done_err);
    else n_pass++;
    n_total++;
    if (acc_cyc.size() < 1 || acc_cyc[0] < 6)
      $display("FAIL stall_hold: first accept cycle index %0d, want it after 5 stall cycles",
               acc_cyc.size() > 0 ? acc_cyc[0] : -1);
    else n_pass++;
    stray_ack = 1'b0;
  endtask

  task automatic test_err();
    clear_stats();
    ack_lat = 1; exp_len = 6; err_on_ack = 3;
    send_cmd(29'h300, 5'd6, 1'b1, 8'h3C);
    wait_done(50);
    n_total++;
    if (done_err !== 1'b1 || cyc_after_err !== 1'b0 || done_cyc !== err_cyc + 1)
      $display("FAIL err_abort: err %b cyc_after %b done_cyc %0d want 1 0 %0d",
               done_err, cyc_after_err, done_cyc, err_cyc + 1);
    else n_pass++;
    @(negedge aclk);
    #2;
    n_total++;
    if (cmd_ready !== 1'b1 || err !== 1'b0)
      $display("FAIL err_recover: cmd_ready %b err %b want 1 0", cmd_ready, err);
    else n_pass++;
    err_on_ack = 0;
  endtask

  task automatic test_back_to_back();
    clear_stats();
    ack_lat = 2; exp_len = 1;
    send_cmd(29'h5, 5'd0, 1'b1, 8'h01);
    wait_done(50);
    n_total++;
    if (n_acc !== 1 || n_wr_ready !== 1 || done_err !== 1'b0)
      $display("FAIL len0_write: acc %0d wr_ready %0d err %b want 1 1 0", n_acc, n_wr_ready, done_err);
    else n_pass++;
    clear_stats();
    exp_len = 16;
    send_cmd(29'h1FFF_FFFE, 5'd20, 1'b0, 8'hFF);
    wait_done(150);
    n_total++;
    if (n_acc !== 16 || n_rd !== 16 || done_err !== 1'b0)
      $display("FAIL clamp_read: acc %0d rd %0d err %b want 16 16 0", n_acc, n_rd, done_err);
    else n_pass++;
    n_total++;
    if (acc_adr.size() < 3 || acc_adr[1] !== 29'h1FFF_FFFF || acc_adr[2] !== 29'h0)
      $display("FAIL adr_wrap: got %h %h want 1fffffff 0",
               acc_adr.size() > 1 ? acc_adr[1] : 'x, acc_adr.size() > 2 ? acc_adr[2] : 'x);
    else n_pass++;
  endtask

  task automatic test_hang();
    int low;
    clear_stats();
    never_ack = 1'b1; exp_len = 1;
    send_cmd(29'h400, 5'd1, 1'b0, 8'hFF);
`ifdef WB_PIPE_TIMEOUT_EN
    wait_done(40);
    n_total++;
    if (done_err !== 1'b1) $display("FAIL timeout_err: err %b want 1", done_err);
    else n_pass++;
`else
    low = 0;
    repeat (20) begin
      @(negedge aclk);
      #2;
      if (!m_wb_cyc) low++;
    end
    n_total++;
    if (low !== 0 || n_done !== 0)
      $display("FAIL hang_wait: cyc low %0d cycles, done %0d, want 0 0", low, n_done);
    else n_pass++;
`endif
    never_ack = 1'b0;
    test_reset();
  endtask

  task automatic test_reset_drain();
    clear_stats();
    ack_lat = 12; exp_len = 4;
    send_cmd(29'h600, 5'd4, 1'b0, 8'hFF);
    repeat (6) @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    #2;
    n_total++;
    if ({m_wb_cyc, m_wb_stb, m_wb_we, rd_valid, done, err} !== 6'b0 || m_wb_adr !== '0 || m_wb_sel !== '0)
      $display("FAIL drain_reset: ctrl %b adr %h sel %h want 0",
               {m_wb_cyc, m_wb_stb, m_wb_we, rd_valid, done, err}, m_wb_adr, m_wb_sel);
    else n_pass++;
    aresetn = 1'b1;
    repeat (15) @(negedge aclk);
    #2;
    n_total++;
    if (n_done !== 0 || exp_rd.size() !== 0)
      $display("FAIL drain_nodone: done %0d pending reads %0d want 0 0", n_done, exp_rd.size());
    else n_pass++;
    clear_stats();
    ack_lat = 1; exp_len = 1;
    send_cmd(29'h700, 5'd1, 1'b0, 8'hFF);
    wait_done(30);
    n_total++;
    if (n_rd !== 1 || done_err !== 1'b0)
      $display("FAIL after_reset_cmd: rd %0d err %b want 1 0", n_rd, done_err);
    else n_pass++;
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_read4();
    test_write8();
    test_stall();
    test_err();
    test_back_to_back();
    test_hang();
    test_reset_drain();
    repeat (3) @(negedge aclk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_pipe_master.md
WB_PIPE_MASTER -- requirements
Module: wb_pipe_master

Interface
REQ-001 Parameter ADDR_WIDTH, 32, byte-address width.
REQ-002 Parameter DATA_WIDTH, 64, data width; BYTE_WIDTH = DATA_WIDTH/8; word-address LSB = clog2(BYTE_WIDTH).
REQ-003 Parameter MAX_BURST, 16, max beats per command; LEN_W = clog2(MAX_BURST)+1.
REQ-004 Parameter MAX_OUT, 4, max issued-but-unacked beats (1..MAX_BURST).
REQ-005 Parameter TIMEOUT_CYCLES, 1024, ack-timeout limit (used only with WB_PIPE_TIMEOUT_EN).
REQ-006 aclk input 1 clock; aresetn input 1 synchronous, active-low reset.
REQ-007 cmd_valid input 1 / cmd_ready output 1: command handshake.
REQ-008 cmd_addr input ADDR_WIDTH-lsb word address of first beat; cmd_len input LEN_W beat count; cmd_we input 1; cmd_sel input BYTE_WIDTH byte enables (all beats).
REQ-009 wr_data input DATA_WIDTH write data for the current beat; wr_ready output 1 pulses when that beat is accepted by the slave.
REQ-010 rd_valid output 1, rd_data output DATA_WIDTH, rd_last output 1: read-beat response.
REQ-011 done output 1 completion pulse; err output 1 error flag, valid with done.
REQ-012 m_wb_cyc, m_wb_stb, m_wb_we outputs 1; m_wb_adr output ADDR_WIDTH-lsb; m_wb_dat_o output DATA_WIDTH; m_wb_sel output BYTE_WIDTH; m_wb_dat_i input DATA_WIDTH; m_wb_ack, m_wb_err, m_wb_stall inputs 1 (Wishbone B4 pipelined).

Function
REQ-013 States: IDLE, ISSUE, DRAIN, DONE; illegal encodings go to IDLE.
REQ-014 cmd_ready = 1 only in IDLE; on cmd_valid && cmd_ready, latch addr/len/we/sel, go ISSUE; cmd_len = 0 treated as 1; cmd_len > MAX_BURST clamped to MAX_BURST.
REQ-015 ISSUE: cyc = 1; stb = 1 while issued < len and outstanding < MAX_OUT; adr = latched addr + issued (wraps modulo 2^(ADDR_WIDTH-lsb)); we/sel from latch; dat_o = wr_data.
REQ-016 Beat accepted when stb && !stall: issued += 1; wr_ready = 1 that cycle if we.
REQ-017 Each m_wb_ack while cyc: acked += 1; if !we, rd_valid = 1 and rd_data = m_wb_dat_i registered (1-cycle latency), rd_last = 1 on final beat.
REQ-018 outstanding = issued - acked; same-cycle accept and ack both counted; outstanding never exceeds MAX_OUT.
REQ-019 ISSUE -> DRAIN when issued == len; DRAIN holds cyc = 1, stb = 0 until acked == len, then DONE.
REQ-020 m_wb_err while cyc: stb and cyc drop next cycle, remaining beats abandoned, err latched, go DONE.
REQ-021 DONE: done = 1 for one cycle, cyc = 0, err reflects latched error; next state IDLE, err cleared on leaving DONE.
REQ-022 Outside ISSUE/DRAIN all Wishbone outputs are 0.
REQ-023 Ack arriving with outstanding == 0 is ignored (no rd_valid, no count change).

Reset
REQ-024 aresetn low: state IDLE, counters 0, cyc/stb/we/adr/dat_o/sel 0, rd_valid/rd_last/done/err 0, rd_data 0; cmd_ready = 1 after reset deasserts.
REQ-025 Reset mid-burst aborts immediately; no done pulse is generated for the aborted command.

Configuration
REQ-026 Macro WB_PIPE_TIMEOUT_EN defined: counter reset on every ack and on entering ISSUE, increments while outstanding > 0; reaching TIMEOUT_CYCLES treated as m_wb_err (REQ-020). Undefined: no counter, master waits indefinitely.

Verification
REQ-027 Read, len 4, addr 0x100, no stall, ack 1 cycle after stb -> adr 0x100..0x103 on consecutive cycles, 4 rd_valid, rd_last on 4th, done 1 cycle after last ack, err 0.
REQ-028 Write, len 8, MAX_OUT 4, slave acks 3 cycles late -> stb drops at outstanding 4, 8 wr_ready pulses, never more than 4 outstanding, done with err 0.
REQ-029 Read, len 2, stall high 5 cycles on first beat -> adr held at first address, exactly 2 accepts, 2 rd_valid.
REQ-030 Write, len 6, m_wb_err on 3rd ack -> cyc low next cycle, done with err 1, then cmd_ready 1.
REQ-031 WB_PIPE_TIMEOUT_EN, TIMEOUT_CYCLES 16, slave never acks -> done with err 1 after 16 cycles; without macro, cyc stays high for the full 16+ cycles.
REQ-032 aresetn low during DRAIN -> all outputs 0 next cycle, no done; new command len 1 completes normally.
